// File: rtl/lbm_step_sequencer.sv
// Time-step controller for the LBM solver: each step runs a collide phase, then a
// stream phase, and then advances the external time step counter.
module lbm_step_sequencer #(
  parameter int MAX_TIME         = 8,
  parameter int TIME_COUNT_WIDTH = $clog2(MAX_TIME),
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int TO_WIDTH         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Start,
  input  logic [TIME_COUNT_WIDTH-1:0] Time_count,
  input  logic                        Collide_done,
  input  logic                        Stream_done,
  output logic                        Collide_start,
  output logic                        Stream_start,
  output logic                        Step_enable,
  output logic                        Busy,
  output logic                        Sim_done,
  output logic                        Error
);

  // With TIMEOUT_CYCLES=0 the watchdog is unused, but it still needs at least one bit.
  localparam int WD_W = (TO_WIDTH > 0) ? TO_WIDTH : 1;
  localparam logic [WD_W-1:0]             WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]             WD_MAX    = '1;
  localparam logic [TIME_COUNT_WIDTH-1:0] LAST_STEP = TIME_COUNT_WIDTH'(MAX_TIME - 1);

  typedef enum logic [3:0] {
    IDLE, COL_REQ, COL_WAIT, STR_REQ, STR_WAIT, ADVANCE, SETTLE, DONE, ERR
  } state_e;

  state_e          state_q, state_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            start_ok;
  logic            wd_expired;

  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    wd_d       = wd_q;
    start_ok   = Start && (Time_count == '0);
    wd_expired = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_ok) state_d = COL_REQ;
      end
      COL_REQ: begin
        state_d = COL_WAIT;
        wd_d    = '0;
      end
      COL_WAIT: begin
        // A done arriving on the last allowed cycle still wins over the watchdog.
        if (Collide_done)        state_d = STR_REQ;
        else if (wd_expired)     state_d = ERR;
        else if (wd_q != WD_MAX) wd_d    = wd_q + WD_W'(1);
      end
      STR_REQ: begin
        state_d = STR_WAIT;
        wd_d    = '0;
      end
      STR_WAIT: begin
        if (Stream_done)         state_d = (Time_count == LAST_STEP) ? DONE : ADVANCE;
        else if (wd_expired)     state_d = ERR;
        else if (wd_q != WD_MAX) wd_d    = wd_q + WD_W'(1);
      end
      ADVANCE: state_d = SETTLE;
      // SETTLE gives the counter a cycle to present the incremented Time_count.
      SETTLE:  state_d = COL_REQ;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that they are registered alongside it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      wd_q          <= '0;
      Collide_start <= 1'b0;
      Stream_start  <= 1'b0;
      Step_enable   <= 1'b0;
      Busy          <= 1'b0;
      Sim_done      <= 1'b0;
      Error         <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q       <= state_d;
      wd_q          <= wd_d;
      Collide_start <= (state_d == COL_REQ);
      Stream_start  <= (state_d == STR_REQ);
      Step_enable   <= (state_d == ADVANCE);
      Busy          <= (state_d inside {COL_REQ, COL_WAIT, STR_REQ, STR_WAIT, ADVANCE, SETTLE});
      Sim_done      <= (state_d == DONE);
      Error         <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_lbm_step_sequencer.sv
// Bench for lbm_step_sequencer: directed vector table, hand-written corner sequences,
// and randomized engine latencies checked against a cycle-arithmetic reference model.
module tb_lbm_step_sequencer;

  localparam int MAXT = 4;
  localparam int TCW  = 2;
  localparam int TO   = 16;
  localparam int NC   = 512;

  typedef struct packed {
    logic cs, ss, se, busy, sd, err;
  } out_t;

  typedef struct {
    logic start, cdone, sdone;
    out_t exp;
  } vec_t;

  typedef int dly_t [MAXT];

  localparam out_t O_IDLE = 6'b000000;
  localparam out_t O_CS   = 6'b100100;
  localparam out_t O_SS   = 6'b010100;
  localparam out_t O_SE   = 6'b001100;
  localparam out_t O_BUSY = 6'b000100;

  logic           Clk = 1'b0;
  logic           Reset, Start;
  logic [TCW-1:0] Time_count;
  logic           Collide_done, Stream_done;
  logic           Collide_start, Stream_start, Step_enable, Busy, Sim_done, Error;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  lbm_step_sequencer #(
    .MAX_TIME       (MAXT),
    .TIME_COUNT_WIDTH(TCW),
    .TIMEOUT_CYCLES (TO),
    .TO_WIDTH       ($clog2(TO + 1))
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Start        (Start),
    .Time_count   (Time_count),
    .Collide_done (Collide_done),
    .Stream_done  (Stream_done),
    .Collide_start(Collide_start),
    .Stream_start (Stream_start),
    .Step_enable  (Step_enable),
    .Busy         (Busy),
    .Sim_done     (Sim_done),
    .Error        (Error)
  );

  // Time step counter sharing Reset; the bench can override it to present any count.
  logic [TCW-1:0] tc_cnt, tc_force_val;
  logic           tc_force;
  always @(posedge Clk or negedge Reset) begin
    if (!Reset)           tc_cnt <= '0;
    else if (Step_enable) tc_cnt <= tc_cnt + TCW'(1);
  end
  assign Time_count = tc_force ? tc_force_val : tc_cnt;

  // Phase engines: each start pops a latency from its queue (0 = never respond).
  logic eng_on, eng_col, eng_str, man_col, man_str;
  int   col_dq[$];
  int   str_dq[$];
  int   col_cnt, str_cnt;
  assign Collide_done = eng_col | man_col;
  assign Stream_done  = eng_str | man_str;

  initial begin
    eng_col = 1'b0;
    eng_str = 1'b0;
    col_cnt = 0;
    str_cnt = 0;
    forever begin
      @(posedge Clk);
      #1;
      eng_col = 1'b0;
      eng_str = 1'b0;
      if (!Reset || !eng_on) begin
        col_cnt = 0;
        str_cnt = 0;
      end else begin
        if (col_cnt > 0) begin
          col_cnt--;
          if (col_cnt == 0) eng_col = 1'b1;
        end
        if (str_cnt > 0) begin
          str_cnt--;
          if (str_cnt == 0) eng_str = 1'b1;
        end
        if (Collide_start && col_dq.size() > 0) col_cnt = col_dq.pop_front();
        if (Stream_start && str_dq.size() > 0)  str_cnt = str_dq.pop_front();
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  function automatic out_t outs();
    out_t o;
    o = {Collide_start, Stream_start, Step_enable, Busy, Sim_done, Error};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset(input int n);
    eng_on   = 1'b0;
    Start    = 1'b0;
    man_col  = 1'b0;
    man_str  = 1'b0;
    tc_force = 1'b0;
    Reset    = 1'b0;
    repeat (n) tick();
    Reset = 1'b1;
    tick();
  endtask

  // Predicts every output cycle by cycle from the engine latencies, then runs the DUT.
  task automatic run(input string name, input dly_t cdl, input dly_t sdl, input bit do_reset,
                     input int pre_idle, output int n_cs, output int n_ss, output int n_se);
    out_t ev [NC];
    int   t, ss, p, end_at, steps;
    bit   is_err;
    out_t o;

    for (int k = 0; k < NC; k++) ev[k] = '0;
    t      = 1;
    end_at = 0;
    steps  = 0;
    is_err = 1'b0;
    for (int s = 0; s < MAXT; s++) begin
      ev[t].cs = 1'b1;
      if (cdl[s] == 0 || cdl[s] > TO) begin
        end_at = t + TO + 1;
        is_err = 1'b1;
        break;
      end
      ss = t + cdl[s] + 1;
      ev[ss].ss = 1'b1;
      if (sdl[s] == 0 || sdl[s] > TO) begin
        end_at = ss + TO + 1;
        is_err = 1'b1;
        break;
      end
      p = ss + sdl[s];
      if (s == MAXT - 1) begin
        end_at = p + 1;
      end else begin
        ev[p + 1].se = 1'b1;
        steps++;
        t = p + 3;
      end
    end
    for (int k = 1; k < end_at; k++) ev[k].busy = 1'b1;
    for (int k = end_at; k <= end_at + 3; k++) begin
      if (is_err) ev[k].err = 1'b1;
      else        ev[k].sd  = 1'b1;
    end

    if (do_reset) apply_reset(3);
    col_dq.delete();
    str_dq.delete();
    for (int s = 0; s < MAXT; s++) begin
      col_dq.push_back(cdl[s]);
      str_dq.push_back(sdl[s]);
    end
    eng_on = 1'b1;
    repeat (pre_idle) tick();

    n_cs = 0;
    n_ss = 0;
    n_se = 0;
    for (int k = 0; k <= end_at + 3; k++) begin
      Start = (k == 0);
      if (k >= 1) begin
        o = outs();
        check($sformatf("%s_cyc%0d", name, k), 32'(o), 32'(ev[k]));
        n_cs += int'(o.cs);
        n_ss += int'(o.ss);
        n_se += int'(o.se);
      end
      tick();
    end
    Start = 1'b0;
    check($sformatf("%s_final_count", name), 32'(Time_count), 32'(steps));
  endtask

  vec_t tbl [16];
  dly_t cd, sd;
  int   a, b, c, seen;

  initial begin
    Start    = 1'b0;
    man_col  = 1'b0;
    man_str  = 1'b0;
    eng_on   = 1'b0;
    tc_force = 1'b0;
    tc_force_val = '0;

    // Reset held 3 cycles, then no Start: the block must sit idle.
    Reset = 1'b0;
    tick();
    check("in_reset", 32'(outs()), 32'(O_IDLE));
    tick();
    tick();
    Reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      check($sformatf("idle_hold%0d", k), 32'(outs()), 32'(O_IDLE));
    end

    // Engines answering one cycle after each start, plus stray done/start pulses.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, O_IDLE};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, O_CS};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, O_BUSY};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, O_SS};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, O_BUSY};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, O_SE};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, O_BUSY};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, O_CS};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, O_BUSY};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, O_BUSY};
    tbl[10] = '{1'b0, 1'b0, 1'b1, O_SS};
    tbl[11] = '{1'b0, 1'b0, 1'b0, O_BUSY};
    tbl[12] = '{1'b0, 1'b0, 1'b1, O_BUSY};
    tbl[13] = '{1'b0, 1'b0, 1'b0, O_SE};
    tbl[14] = '{1'b0, 1'b0, 1'b0, O_BUSY};
    tbl[15] = '{1'b0, 1'b0, 1'b0, O_CS};
    apply_reset(3);
    for (int i = 0; i < 16; i++) begin
      Start   = tbl[i].start;
      man_col = tbl[i].cdone;
      man_str = tbl[i].sdone;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
      tick();
    end
    Start   = 1'b0;
    man_col = 1'b0;
    man_str = 1'b0;

    // Start refused while Time_count is nonzero, stray Collide_done in IDLE.
    apply_reset(3);
    tc_force     = 1'b1;
    tc_force_val = TCW'(2);
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("start_tc2_%0d", k), 32'(outs()), 32'(O_IDLE));
      tick();
    end
    man_col = 1'b1;
    tick();
    man_col = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stray_cdone_%0d", k), 32'(outs()), 32'(O_IDLE));
      tick();
    end
    tc_force = 1'b0;
    Start    = 1'b1;
    tick();
    Start = 1'b0;
    check("start_after_ignored", 32'(outs()), 32'(O_CS));

    // Full run, engines 5 cycles, Start 10 cycles after reset release.
    run("full5", '{5, 5, 5, 5}, '{5, 5, 5, 5}, 1'b1, 10, a, b, c);
    check("full5_n_cs", 32'(a), 32'd4);
    check("full5_n_ss", 32'(b), 32'd4);
    check("full5_n_se", 32'(c), 32'd3);

    // Stream engine silent: error, then restart from ERR without reset.
    run("timeout", '{5, 5, 5, 5}, '{0, 0, 0, 0}, 1'b1, 2, a, b, c);
    check("timeout_n_se", 32'(c), 32'd0);
    run("restart", '{3, 3, 3, 3}, '{3, 3, 3, 3}, 1'b0, 0, a, b, c);

    // Watchdog boundary: 16 cycles is in time, 17 is too late.
    run("edge16", '{16, 16, 16, 16}, '{16, 16, 16, 16}, 1'b1, 1, a, b, c);
    run("edge17", '{2, 2, 2, 2}, '{2, 17, 2, 2}, 1'b1, 1, a, b, c);

    // Reset asserted mid-cycle in STR_WAIT of the second step.
    apply_reset(3);
    col_dq.delete();
    str_dq.delete();
    for (int s = 0; s < MAXT; s++) begin
      col_dq.push_back(2);
      str_dq.push_back(2);
    end
    eng_on = 1'b1;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    seen  = 0;
    for (int g = 0; g < 200 && seen < 2; g++) begin
      if (Stream_start) seen++;
      if (seen < 2) tick();
    end
    check("rst_reach_str2", 32'(seen), 32'd2);
    tick();
    check("rst_pre_busy", 32'(Busy), 32'd1);
    check("rst_pre_tc", 32'(Time_count), 32'd1);
    #2;
    Reset = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs()), 32'(O_IDLE));
    check("rst_async_tc", 32'(Time_count), 32'd0);
    eng_on = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    tick();
    run("after_rst", '{2, 2, 2, 2}, '{2, 2, 2, 2}, 1'b0, 2, a, b, c);

    // Randomized engine latencies, occasionally beyond the watchdog limit.
    for (int r = 0; r < 12; r++) begin
      for (int s = 0; s < MAXT; s++) begin
        cd[s] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(17, 18)) : int'($urandom_range(1, 16));
        sd[s] = ($urandom_range(0, 11) == 0) ? int'($urandom_range(17, 18)) : int'($urandom_range(1, 16));
      end
      run($sformatf("rand%0d", r), cd, sd, 1'b1, int'($urandom_range(0, 5)), a, b, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lbm_step_sequencer.md
Name: lbm_step_sequencer

Overview:
Top-level time-step controller for the LBM solver. It generates the advance strobe that drives the time step counter's Enable, and reads that counter's count back. For each time step it runs a collide phase then a stream phase through start/done handshakes with the phase engines. After the step whose count is MAX_TIME-1 it asserts Sim_done instead of advancing; a per-phase watchdog flags engines that never report done.

Parameters:
MAX_TIME, 8, number of time steps per run; must match the time step counter instance.
TIME_COUNT_WIDTH, $clog2(MAX_TIME), width of Time_count.
TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for any phase done; 0 disables the watchdog.
TO_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the watchdog counter.

Ports:
Clk  input  1  system clock, all state changes on posedge.
Reset  input  1  asynchronous, active-low reset.
Start  input  1  single-cycle run request.
Time_count  input  TIME_COUNT_WIDTH  current step, from the time step counter's Data_out.
Collide_done  input  1  single-cycle pulse: collide phase finished.
Stream_done  input  1  single-cycle pulse: stream phase finished.
Collide_start  output  1  single-cycle pulse launching the collide phase.
Stream_start  output  1  single-cycle pulse launching the stream phase.
Step_enable  output  1  single-cycle pulse to the counter's Enable.
Busy  output  1  high while a run is in progress.
Sim_done  output  1  sticky: all MAX_TIME steps completed.
Error  output  1  sticky: watchdog expired.

Behaviour:
- Reset (Reset=0, any state, asynchronous):
  - State goes to IDLE; all outputs go to 0; watchdog cleared.
  - The counter shares Reset, so Time_count returns to 0 together with this block.
- States: IDLE, COL_REQ, COL_WAIT, STR_REQ, STR_WAIT, ADVANCE, SETTLE, DONE, ERR.
- Start is accepted in IDLE, DONE or ERR, and only when Time_count==0.
  - Otherwise it is ignored; there is no state change.
  - Acceptance clears Sim_done and Error and moves to COL_REQ.
  - Start in any other state is ignored.
- COL_REQ: Collide_start=1 for exactly this cycle, then COL_WAIT.
- COL_WAIT: on Collide_done, go to STR_REQ.
- STR_REQ: Stream_start=1 for exactly this cycle, then STR_WAIT.
- STR_WAIT: on Stream_done:
  - If Time_count==MAX_TIME-1, go to DONE (no Step_enable pulse).
  - Otherwise go to ADVANCE.
- ADVANCE: Step_enable=1 for exactly this cycle, then SETTLE.
- SETTLE: one idle cycle so the incremented Time_count is stable, then COL_REQ.
- DONE: Sim_done=1 (registered, visible the cycle after Stream_done); hold until an accepted Start or Reset.
- ERR: Error=1; hold until an accepted Start or Reset.
- Busy=1 in COL_REQ through SETTLE; Busy=0 in IDLE, DONE and ERR.
- Done pulses are honoured only in their own WAIT state:
  - Collide_done is ignored outside COL_WAIT; Stream_done is ignored outside STR_WAIT.
  - A done pulse arriving in a REQ cycle is lost; engines must respond no earlier than one cycle after their start pulse.
- Latency:
  - Start at cycle n -> Collide_start at n+1.
  - Collide_done at m -> Stream_start at m+1.
  - Stream_done at p (non-final step) -> Step_enable at p+1, Collide_start at p+3.
- Watchdog (TIMEOUT_CYCLES>0):
  - Cleared on entry to COL_WAIT and STR_WAIT; increments each cycle in a WAIT state with no done.
  - When it equals TIMEOUT_CYCLES-1 with no done that cycle, go to ERR.
  - A done arriving on that same cycle wins; there is no error.
  - Saturating; no wrap.
- Outputs are registered (Moore); no combinational path from inputs to outputs.

Test Plan:
- Reset held low for 3 cycles, then released with no Start -> all outputs 0 and the block stays in IDLE indefinitely.
- MAX_TIME=4, engines return done 5 cycles after start, Start at cycle 10 (Time_count=0):
  - 4 Collide_start and 4 Stream_start pulses; 3 Step_enable pulses.
  - Time_count steps 0,1,2,3; Sim_done rises the cycle after the 4th Stream_done; Busy falls the same cycle.
- Engines return done 1 cycle after start -> Collide_start at n+1, Stream_start at n+3, Step_enable at n+5, next Collide_start at n+7.
- Start with Time_count forced to 2; a spurious Collide_done pulsed in IDLE; Start re-pulsed mid-run -> all ignored, with no state or output change.
- TIMEOUT_CYCLES=16, Stream_done never asserted -> Error=1 exactly 16 cycles after entering STR_WAIT, Busy=0, no Step_enable. A subsequent Start with Time_count=0 clears Error and restarts the run.
- Reset asserted in STR_WAIT during the 2nd step -> outputs 0 immediately (asynchronously) and Time_count returns to 0. After release, Start runs a full MAX_TIME-step run to Sim_done.
